// File: rtl/coeff_buffer_controller.sv
// Coefficient buffer controller. It tracks the write, commit and release
// pointers of a circular coefficient RAM that sits between the VLD (writer)
// and the inverse quantiser (reader). It also handles the flush handshake
// and the macroblock bookkeeping.
module coeff_buffer_controller #(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              Start_I,
    input  logic              Wr_Req_I,
    input  logic [31:0]       Wr_Data_I,
    output logic              Wr_Grant_O,
    input  logic              Wr_Commit_I,
    input  logic              Wr_Abort_I,
    output logic              Ram_Wr_En_O,
    output logic [ADDR_W-1:0] Ram_Wr_Address_O,
    output logic [31:0]       Ram_Wr_Data_O,
    input  logic              MB_Done_I,
    input  logic [ADDR_W:0]   Rd_Release_Address_I,
    input  logic              Reader_Busy_I,
    input  logic              Flush_I,
    output logic              Coeff_Buffer_Empty_O,
    output logic              Coeff_Buffer_Full_O,
    output logic              Coeff_Buffer_Reset_O,
    output logic [ADDR_W:0]   Coeff_Buffer_Reset_Address_O,
    output logic [7:0]        MB_Count_O,
    output logic [ADDR_W:0]   Level_O
);

    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH = PW'(1) << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH_WAIT,
        ST_FLUSH
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]   rel_ptr_q, rel_ptr_d;
    logic [7:0]      mb_count_q, mb_count_d;

    logic            in_run;
    logic            in_flush_wait;
    logic            in_flush;
    logic            count_max;
    logic            grant;
    logic            commit_ok;
    logic            done_ok;
    logic            abort_ok;
    logic [PW-1:0]   level;
    logic [PW-1:0]   wr_ptr_inc;

    // Status decode and the zero-latency write grant path.
    always_comb begin
        in_run        = (state_q == ST_RUN);
        in_flush_wait = (state_q == ST_FLUSH_WAIT);
        in_flush      = (state_q == ST_FLUSH);
        // Wrap bit kept as MSB so the modulo difference separates empty (0) from full (DEPTH).
        level         = wr_ptr_q - rel_ptr_q;
        count_max     = (mb_count_q == 8'hFF);
        grant         = Wr_Req_I & in_run & (level != DEPTH) & ~Wr_Abort_I & ~count_max;
        wr_ptr_inc    = wr_ptr_q + PW'(grant);
        abort_ok      = in_run & Wr_Abort_I;
        // Abort wins over commit; a saturated counter cannot take another macroblock.
        commit_ok     = in_run & Wr_Commit_I & ~Wr_Abort_I & ~count_max;
        done_ok       = (in_run | in_flush_wait) & MB_Done_I & (mb_count_q != 8'd0);
    end

    // Next-state logic for the FSM, the pointers and the macroblock counter.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path infers a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        rel_ptr_d  = rel_ptr_q;
        mb_count_d = mb_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (Start_I) state_d = ST_RUN;
            end
            ST_RUN: begin
                // The busy check is made in the same evaluation as entry, so an idle
                // reader sends the flush straight through.
                if (Flush_I) state_d = Reader_Busy_I ? ST_FLUSH_WAIT : ST_FLUSH;
            end
            ST_FLUSH_WAIT: begin
                if (!Reader_Busy_I) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort rolls the writer back to the last commit boundary.
        if (abort_ok) wr_ptr_d = cm_ptr_q;
        else          wr_ptr_d = wr_ptr_inc;

        // The commit boundary includes a word granted in the same cycle.
        if (commit_ok) cm_ptr_d = wr_ptr_inc;

        if (done_ok) rel_ptr_d = Rd_Release_Address_I;

        // A commit and a release in the same cycle cancel out in the count.
        unique case ({commit_ok, done_ok})
            2'b10:   mb_count_d = mb_count_q + 8'd1;
            2'b01:   mb_count_d = mb_count_q - 8'd1;
            default: mb_count_d = mb_count_q;
        endcase

        if (in_flush) begin
            wr_ptr_d   = '0;
            cm_ptr_d   = '0;
            rel_ptr_d  = '0;
            mb_count_d = '0;
        end
    end

    // State and pointer registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cm_ptr_q   <= '0;
            rel_ptr_q  <= '0;
            mb_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cm_ptr_q   <= cm_ptr_d;
            rel_ptr_q  <= rel_ptr_d;
            mb_count_q <= mb_count_d;
        end
    end

    assign Wr_Grant_O                   = grant;
    assign Ram_Wr_En_O                  = grant;
    assign Ram_Wr_Address_O             = wr_ptr_q[ADDR_W-1:0];
    assign Ram_Wr_Data_O                = Wr_Data_I;
    assign Coeff_Buffer_Empty_O         = (mb_count_q == 8'd0);
    assign Coeff_Buffer_Full_O          = (level == DEPTH);
    assign Coeff_Buffer_Reset_O         = in_flush;
    assign Coeff_Buffer_Reset_Address_O = in_flush ? '0 : cm_ptr_q;
    assign MB_Count_O                   = mb_count_q;
    assign Level_O                      = level;

endmodule

// File: tb/tb_coeff_buffer_controller.sv
// Directed testbench for coeff_buffer_controller with ADDR_W=4 (DEPTH=16).
module tb_coeff_buffer_controller;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          Start_I;
    logic          Wr_Req_I;
    logic [31:0]   Wr_Data_I;
    logic          Wr_Grant_O;
    logic          Wr_Commit_I;
    logic          Wr_Abort_I;
    logic          Ram_Wr_En_O;
    logic [AW-1:0] Ram_Wr_Address_O;
    logic [31:0]   Ram_Wr_Data_O;
    logic          MB_Done_I;
    logic [AW:0]   Rd_Release_Address_I;
    logic          Reader_Busy_I;
    logic          Flush_I;
    logic          Coeff_Buffer_Empty_O;
    logic          Coeff_Buffer_Full_O;
    logic          Coeff_Buffer_Reset_O;
    logic [AW:0]   Coeff_Buffer_Reset_Address_O;
    logic [7:0]    MB_Count_O;
    logic [AW:0]   Level_O;

    int n_asserts = 0;
    int n_fail    = 0;

    coeff_buffer_controller #(.ADDR_W(AW)) dut (
        .clock                        (clock),
        .reset                        (reset),
        .Start_I                      (Start_I),
        .Wr_Req_I                     (Wr_Req_I),
        .Wr_Data_I                    (Wr_Data_I),
        .Wr_Grant_O                   (Wr_Grant_O),
        .Wr_Commit_I                  (Wr_Commit_I),
        .Wr_Abort_I                   (Wr_Abort_I),
        .Ram_Wr_En_O                  (Ram_Wr_En_O),
        .Ram_Wr_Address_O             (Ram_Wr_Address_O),
        .Ram_Wr_Data_O                (Ram_Wr_Data_O),
        .MB_Done_I                    (MB_Done_I),
        .Rd_Release_Address_I         (Rd_Release_Address_I),
        .Reader_Busy_I                (Reader_Busy_I),
        .Flush_I                      (Flush_I),
        .Coeff_Buffer_Empty_O         (Coeff_Buffer_Empty_O),
        .Coeff_Buffer_Full_O          (Coeff_Buffer_Full_O),
        .Coeff_Buffer_Reset_O         (Coeff_Buffer_Reset_O),
        .Coeff_Buffer_Reset_Address_O (Coeff_Buffer_Reset_Address_O),
        .MB_Count_O                   (MB_Count_O),
        .Level_O                      (Level_O)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs.
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        Start_I              = 1'b0;
        Wr_Req_I             = 1'b0;
        Wr_Data_I            = 32'h0;
        Wr_Commit_I          = 1'b0;
        Wr_Abort_I           = 1'b0;
        MB_Done_I            = 1'b0;
        Rd_Release_Address_I = '0;
        Reader_Busy_I        = 1'b0;
        Flush_I              = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start();
        Start_I = 1'b1;
        tick();
        Start_I = 1'b0;
    endtask

    // One granted write; optionally committed in the same cycle.
    task automatic write_word(input string tag, input logic [31:0] d, input logic commit,
                              input logic [31:0] exp_addr);
        Wr_Req_I    = 1'b1;
        Wr_Data_I   = d;
        Wr_Commit_I = commit;
        settle();
        check({tag, "_grant"}, 32'(Wr_Grant_O), 32'd1);
        check({tag, "_addr"}, 32'(Ram_Wr_Address_O), exp_addr);
        check({tag, "_data"}, Ram_Wr_Data_O, d);
        tick();
        Wr_Req_I    = 1'b0;
        Wr_Commit_I = 1'b0;
    endtask

    task automatic check_reset_values(input string tag, input logic [31:0] d);
        check({tag, "_grant"}, 32'(Wr_Grant_O), 32'd0);
        check({tag, "_wr_en"}, 32'(Ram_Wr_En_O), 32'd0);
        check({tag, "_addr"}, 32'(Ram_Wr_Address_O), 32'd0);
        check({tag, "_data"}, Ram_Wr_Data_O, d);
        check({tag, "_empty"}, 32'(Coeff_Buffer_Empty_O), 32'd1);
        check({tag, "_full"}, 32'(Coeff_Buffer_Full_O), 32'd0);
        check({tag, "_rst_pulse"}, 32'(Coeff_Buffer_Reset_O), 32'd0);
        check({tag, "_rst_addr"}, 32'(Coeff_Buffer_Reset_Address_O), 32'd0);
        check({tag, "_mb_count"}, 32'(MB_Count_O), 32'd0);
        check({tag, "_level"}, 32'(Level_O), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- Reset values, writes refused in IDLE ----
        do_reset();
        Wr_Req_I  = 1'b1;
        Wr_Data_I = 32'hDEAD_BEEF;
        settle();
        check_reset_values("rst", 32'hDEAD_BEEF);
        tick();
        check("idle_grant", 32'(Wr_Grant_O), 32'd0);
        Wr_Req_I = 1'b0;

        // ---- Basic commit: 5 words, commit on the 5th ----
        do_start();
        for (int i = 0; i < 5; i++)
            write_word("basic", 32'h100 + 32'(i), (i == 4), 32'(i));
        check("basic_mb_count", 32'(MB_Count_O), 32'd1);
        check("basic_empty", 32'(Coeff_Buffer_Empty_O), 32'd0);
        check("basic_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd5);
        check("basic_level", 32'(Level_O), 32'd5);
        MB_Done_I = 1'b1;
        Rd_Release_Address_I = 5'd5;
        tick();
        check("release_mb_count", 32'(MB_Count_O), 32'd0);
        check("release_empty", 32'(Coeff_Buffer_Empty_O), 32'd1);
        check("release_level", 32'(Level_O), 32'd0);
        // MB_Done with nothing committed must not move the release pointer.
        Rd_Release_Address_I = 5'd9;
        tick();
        MB_Done_I = 1'b0;
        check("done_at_zero_level", 32'(Level_O), 32'd0);
        check("done_at_zero_count", 32'(MB_Count_O), 32'd0);

        // ---- Abort: commit after 3, write 4 more, abort with request and commit ----
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++)
            write_word("ab_pre", 32'h200 + 32'(i), (i == 2), 32'(i));
        for (int i = 3; i < 7; i++)
            write_word("ab_unc", 32'h200 + 32'(i), 1'b0, 32'(i));
        check("ab_level_before", 32'(Level_O), 32'd7);
        Wr_Req_I    = 1'b1;
        Wr_Abort_I  = 1'b1;
        Wr_Commit_I = 1'b1;
        settle();
        check("ab_grant", 32'(Wr_Grant_O), 32'd0);
        check("ab_wr_en", 32'(Ram_Wr_En_O), 32'd0);
        tick();
        idle_inputs();
        check("ab_level_after", 32'(Level_O), 32'd3);
        check("ab_mb_count", 32'(MB_Count_O), 32'd1);
        check("ab_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd3);
        write_word("ab_next", 32'h2FF, 1'b1, 32'd3);
        check("ab_next_count", 32'(MB_Count_O), 32'd2);
        check("ab_next_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd4);

        // ---- Simultaneous commit and MB_Done ----
        MB_Done_I = 1'b1;
        Rd_Release_Address_I = 5'd3;
        tick();
        MB_Done_I = 1'b0;
        check("sim_pre_count", 32'(MB_Count_O), 32'd1);
        check("sim_pre_level", 32'(Level_O), 32'd1);
        Wr_Req_I    = 1'b1;
        Wr_Data_I   = 32'h333;
        Wr_Commit_I = 1'b1;
        MB_Done_I   = 1'b1;
        Rd_Release_Address_I = 5'd4;
        settle();
        check("sim_addr", 32'(Ram_Wr_Address_O), 32'd4);
        tick();
        idle_inputs();
        check("sim_count", 32'(MB_Count_O), 32'd1);
        check("sim_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd5);
        check("sim_level", 32'(Level_O), 32'd1);

        // ---- Full and wrap ----
        do_reset();
        do_start();
        for (int i = 0; i < 16; i++)
            write_word("fill", 32'h400 + 32'(i), (i == 15), 32'(i));
        check("full_flag", 32'(Coeff_Buffer_Full_O), 32'd1);
        check("full_level", 32'(Level_O), 32'd16);
        check("full_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd16);
        Wr_Req_I = 1'b1;
        settle();
        check("full_17_grant", 32'(Wr_Grant_O), 32'd0);
        check("full_17_wr_en", 32'(Ram_Wr_En_O), 32'd0);
        tick();
        Wr_Req_I = 1'b0;
        check("full_17_level", 32'(Level_O), 32'd16);
        MB_Done_I = 1'b1;
        Rd_Release_Address_I = 5'd16;
        tick();
        idle_inputs();
        check("wrap_full", 32'(Coeff_Buffer_Full_O), 32'd0);
        check("wrap_level", 32'(Level_O), 32'd0);
        check("wrap_count", 32'(MB_Count_O), 32'd0);
        write_word("wrap_write", 32'h4AA, 1'b1, 32'd0);
        check("wrap_level_after", 32'(Level_O), 32'd1);
        check("wrap_wr_ptr", 32'(Coeff_Buffer_Reset_Address_O), 32'd17);

        // ---- Flush while the reader is busy ----
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++)
            write_word("fl_pre", 32'h500 + 32'(i), (i == 2), 32'(i));
        Flush_I       = 1'b1;
        Reader_Busy_I = 1'b1;
        tick();
        Flush_I = 1'b0;
        for (int c = 0; c < 4; c++) begin
            Wr_Req_I    = 1'b1;
            Wr_Commit_I = 1'b1;
            settle();
            check("fw_grant", 32'(Wr_Grant_O), 32'd0);
            check("fw_rst_pulse", 32'(Coeff_Buffer_Reset_O), 32'd0);
            tick();
        end
        Wr_Req_I    = 1'b0;
        Wr_Commit_I = 1'b0;
        check("fw_count", 32'(MB_Count_O), 32'd1);
        check("fw_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd3);
        Reader_Busy_I = 1'b0;
        tick();
        check("flush_pulse", 32'(Coeff_Buffer_Reset_O), 32'd1);
        check("flush_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd0);
        tick();
        check("post_flush_pulse", 32'(Coeff_Buffer_Reset_O), 32'd0);
        check("post_flush_count", 32'(MB_Count_O), 32'd0);
        check("post_flush_level", 32'(Level_O), 32'd0);
        check("post_flush_empty", 32'(Coeff_Buffer_Empty_O), 32'd1);
        check("post_flush_rst_addr", 32'(Coeff_Buffer_Reset_Address_O), 32'd0);
        write_word("post_flush_write", 32'h5AA, 1'b0, 32'd0);

        // ---- Reset during FLUSH_WAIT with three macroblocks pending ----
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++)
            write_word("mr_pre", 32'h600 + 32'(i), 1'b1, 32'(i));
        check("mr_count", 32'(MB_Count_O), 32'd3);
        Flush_I       = 1'b1;
        Reader_Busy_I = 1'b1;
        tick();
        Flush_I   = 1'b0;
        reset     = 1'b1;
        Wr_Req_I  = 1'b1;
        Wr_Data_I = 32'hCAFE_F00D;
        tick();
        reset = 1'b0;
        settle();
        check_reset_values("mr", 32'hCAFE_F00D);
        tick();
        check("mr_idle_grant", 32'(Wr_Grant_O), 32'd0);
        Wr_Req_I      = 1'b0;
        Reader_Busy_I = 1'b0;
        do_start();
        write_word("mr_restart", 32'h6AA, 1'b0, 32'd0);

        // ---- Macroblock counter saturation at 255 ----
        do_reset();
        do_start();
        Wr_Commit_I = 1'b1;
        for (int i = 0; i < 255; i++) tick();
        Wr_Commit_I = 1'b0;
        check("sat_count", 32'(MB_Count_O), 32'd255);
        Wr_Req_I    = 1'b1;
        Wr_Commit_I = 1'b1;
        settle();
        check("sat_grant", 32'(Wr_Grant_O), 32'd0);
        tick();
        idle_inputs();
        check("sat_commit_ignored", 32'(MB_Count_O), 32'd255);
        MB_Done_I = 1'b1;
        tick();
        MB_Done_I = 1'b0;
        check("sat_done", 32'(MB_Count_O), 32'd254);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
